inst_issue_ctrl: RTL

INST_ISSUE_CTRL -- requirements
Module: inst_issue_ctrl

---
 rtl/inst_issue_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/inst_issue_ctrl.sv
// Instruction issue controller: fetches words from a ROM, issues them to a core one at a time
// and follows the core's next-PC. Optional WAIT timeout enabled by defining ISSUE_TIMEOUT_EN.
module inst_issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  inst_count,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        core_in_valid,
    output logic [31:0] core_inst,
    input  logic        core_out_valid,
    input  logic [31:0] core_inst_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  retired
);

    typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StError} state_e;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  retired_q, retired_d;
    logic [9:0]  addr_q, addr_d;
    logic        done_q, done_d;
    logic        addr_ok;
    logic [7:0]  retired_inc;
`ifdef ISSUE_TIMEOUT_EN
    logic [3:0]  tmo_q, tmo_d;
`endif

    // Only word-aligned PCs inside the 4 KiB ROM window are legal.
    assign addr_ok     = (core_inst_addr[1:0] == 2'b00) && (core_inst_addr[31:12] == 20'h0);
    assign retired_inc = (retired_q == 8'hff) ? retired_q : retired_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        retired_d = retired_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
`ifdef ISSUE_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        unique case (state_q)
            StIdle, StError: begin
                if (start) begin
                    count_d   = inst_count;
                    pc_d      = 12'h0;
                    retired_d = 8'h0;
                    if (inst_count != 8'h0) begin
                        state_d = StFetch;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StFetch: begin
                addr_d  = pc_q[11:2];
                state_d = core_out_valid ? StError : StIssue;
            end
            StIssue: begin
`ifdef ISSUE_TIMEOUT_EN
                tmo_d   = 4'd0;
`endif
                state_d = core_out_valid ? StError : StWait;
            end
            StWait: begin
                if (core_out_valid) begin
                    if (!addr_ok) begin
                        state_d = StError;
                    end else begin
                        pc_d      = core_inst_addr[11:0];
                        retired_d = retired_inc;
                        if (retired_inc == count_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StFetch;
                        end
                    end
                end
`ifdef ISSUE_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 4'd1;
                    if (tmo_q == 4'd9) begin
                        state_d = StError;
                    end
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= 12'h0;
            count_q   <= 8'h0;
            retired_q <= 8'h0;
            addr_q    <= 10'h0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            retired_q <= retired_d;
            addr_q    <= addr_d;
            done_q    <= done_d;
        end
    end

`ifdef ISSUE_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= 4'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // The fetch address is presented combinationally in FETCH and held afterwards.
    assign imem_addr     = (state_q == StFetch) ? pc_q[11:2] : addr_q;
    assign core_in_valid = (state_q == StIssue);
    assign core_inst     = (state_q == StIssue) ? imem_rdata : 32'h0;
    assign busy          = (state_q == StFetch) || (state_q == StIssue) || (state_q == StWait);
    assign done          = done_q;
    assign error         = (state_q == StError);
    assign retired       = retired_q;

endmodule
